// File: rtl/debug_loader_ctrl.sv
// UART debug loader: fills instruction memory from a byte stream, runs or steps
// the CPU, then reports the captured PC back over UART as four MSB-first bytes.
module debug_loader_ctrl #(
  parameter int unsigned          NB_ADDR   = 32,
  parameter int unsigned          NB_INST   = 32,
  parameter int unsigned          DBIT      = 8,
  parameter logic [NB_INST-1:0]   HALT_INST = NB_INST'(32'hFFFFFFFF)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [DBIT-1:0]    i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic               i_cpu_halt,
  input  logic [NB_ADDR-1:0] i_pc,
  output logic [DBIT-1:0]    o_tx_data,
  output logic               o_wr_uart,
  output logic [NB_ADDR-1:0] o_imem_addr,
  output logic [NB_INST-1:0] o_imem_data,
  output logic               o_imem_we,
  output logic               o_cpu_enable,
  output logic               o_busy
);

  localparam int unsigned PCW = 4 * DBIT;
  localparam int unsigned WRW = NB_INST - DBIT;

  localparam logic [DBIT-1:0] CMD_LOAD = DBIT'(8'h4C);
  localparam logic [DBIT-1:0] CMD_RUN  = DBIT'(8'h43);
  localparam logic [DBIT-1:0] CMD_STEP = DBIT'(8'h53);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RUN, STEP, SEND} state_t;

  state_t             state;
  logic               loaded;
  logic [NB_ADDR-1:0] addr_cnt;
  logic [1:0]         byte_cnt;
  logic [WRW-1:0]     word;     // first three bytes of the word being assembled
  logic [PCW-1:0]     pc_buf;
  logic [1:0]         tx_cnt;
  logic               tx_wait;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      loaded       <= 1'b0;
      addr_cnt     <= '0;
      byte_cnt     <= '0;
      word         <= '0;
      pc_buf       <= '0;
      tx_cnt       <= '0;
      tx_wait      <= 1'b0;
      o_tx_data    <= '0;
      o_wr_uart    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_data  <= '0;
      o_imem_we    <= 1'b0;
      o_cpu_enable <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_imem_we <= 1'b0;
      o_wr_uart <= 1'b0;
      case (state)
        IDLE: begin
          if (i_rx_done) begin
            if (i_rx_data == CMD_LOAD) begin
              state    <= LOAD;
              o_busy   <= 1'b1;
              addr_cnt <= '0;
              byte_cnt <= '0;
              loaded   <= 1'b0;
            end else if (i_rx_data == CMD_RUN && loaded) begin
              state        <= RUN;
              o_busy       <= 1'b1;
              o_cpu_enable <= 1'b1;
            end else if (i_rx_data == CMD_STEP && loaded) begin
              o_busy <= 1'b1;
              // An already-halted CPU is not stepped; just report its PC
              if (i_cpu_halt) begin
                state   <= SEND;
                pc_buf  <= PCW'(i_pc);
                tx_cnt  <= '0;
                tx_wait <= 1'b0;
              end else begin
                state        <= STEP;
                o_cpu_enable <= 1'b1;
              end
            end
          end
        end
        LOAD: begin
          if (i_rx_done) begin
            if (byte_cnt == 2'd3) begin
              state       <= WRITE;
              o_imem_we   <= 1'b1;
              o_imem_addr <= addr_cnt;
              o_imem_data <= {word, i_rx_data};
              byte_cnt    <= '0;
            end else begin
              word     <= {word[WRW-DBIT-1:0], i_rx_data};
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        WRITE: begin
          addr_cnt <= addr_cnt + NB_ADDR'(4);
          if (o_imem_data == HALT_INST) begin
            loaded <= 1'b1;
            state  <= IDLE;
            o_busy <= 1'b0;
          end else begin
            state <= LOAD;
          end
        end
        RUN: begin
          if (i_cpu_halt) begin
            o_cpu_enable <= 1'b0;
            state        <= SEND;
            pc_buf       <= PCW'(i_pc);
            tx_cnt       <= '0;
            tx_wait      <= 1'b0;
          end
        end
        STEP: begin
          o_cpu_enable <= 1'b0;
          state        <= SEND;
          pc_buf       <= PCW'(i_pc);
          tx_cnt       <= '0;
          tx_wait      <= 1'b0;
        end
        SEND: begin
          // Strobe one byte, then hold it until the transmitter reports done
          if (!tx_wait) begin
            o_tx_data <= pc_buf[PCW-1 -: DBIT];
            o_wr_uart <= 1'b1;
            tx_wait   <= 1'b1;
            pc_buf    <= pc_buf << DBIT;
          end else if (i_tx_done) begin
            tx_wait <= 1'b0;
            if (tx_cnt == 2'd3) begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end else begin
              tx_cnt <= tx_cnt + 2'd1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/debug_loader_ctrl.md
DEBUG_LOADER_CTRL -- requirements
Module: debug_loader_ctrl

Interface
REQ-001 SHALL have parameter NB_ADDR, default 32, instruction-memory byte-address width.
REQ-002 SHALL have parameter NB_INST, default 32, instruction word width (fixed at 4 bytes).
REQ-003 SHALL have parameter DBIT, default 8, UART byte width.
REQ-004 SHALL have parameter HALT_INST, default 32'hFFFFFFFF, program terminator word.
REQ-005 SHALL have one clock; reset is asynchronous and active-high (i_clk, i_reset).
REQ-006 SHALL have ports:
- i_clk  in  1  rising-edge clock
- i_reset  in  1  async active-high reset
- i_rx_data  in  DBIT  received UART byte
- i_rx_done  in  1  one-cycle pulse, i_rx_data valid
- i_tx_done  in  1  one-cycle pulse, current TX byte finished
- i_cpu_halt  in  1  CPU has retired HALT_INST
- i_pc  in  NB_ADDR  current CPU PC
- o_tx_data  out  DBIT  byte to transmit
- o_wr_uart  out  1  one-cycle TX start strobe
- o_imem_addr  out  NB_ADDR  instruction-memory write byte address
- o_imem_data  out  NB_INST  instruction-memory write data
- o_imem_we  out  1  one-cycle write strobe
- o_cpu_enable  out  1  CPU clock-enable
- o_busy  out  1  high whenever state != IDLE

Function
REQ-007 SHALL implement FSM states IDLE, LOAD, WRITE, RUN, STEP, SEND.
REQ-008 SHALL decode commands only in IDLE: 0x4C 'L' -> LOAD; 0x43 'C' -> RUN; 0x53 'S' -> STEP; any other byte ignored, no state change.
REQ-009 SHALL ignore 'C' and 'S' while the internal loaded flag is 0.
REQ-010 SHALL, on entering LOAD, clear the address counter to 0, clear the byte counter, and clear the loaded flag.
REQ-011 SHALL, in LOAD, shift each i_rx_data into the word register MSB-first (first byte = bits 31:24).
REQ-012 SHALL, on the 4th byte's i_rx_done at cycle n, go to WRITE and assert o_imem_we for exactly cycle n+1 with o_imem_addr = counter and o_imem_data = assembled word.
REQ-013 SHALL increment the address counter by 4 after each write, modulo 2^NB_ADDR (wrap silently).
REQ-014 SHALL, after writing a word equal to HALT_INST, set the loaded flag and return to IDLE; otherwise return to LOAD with byte counter 0.
REQ-015 SHALL, in RUN, hold o_cpu_enable high from the cycle after entry until the first cycle i_cpu_halt is sampled high, then deassert it on the next edge and go to SEND.
REQ-016 SHALL, in STEP, assert o_cpu_enable for exactly one cycle then go to SEND; if i_cpu_halt is already high on 'S', go to SEND without asserting o_cpu_enable.
REQ-017 SHALL, on entering SEND, capture i_pc and transmit it as 4 bytes MSB-first: o_wr_uart high one cycle with o_tx_data valid, then wait for i_tx_done before the next byte.
REQ-018 SHALL hold o_tx_data stable from its o_wr_uart strobe until the matching i_tx_done.
REQ-019 SHALL return to IDLE on the 4th i_tx_done.
REQ-020 SHALL ignore i_rx_done in WRITE, RUN, STEP and SEND (no buffering of dropped bytes).
REQ-021 SHALL ignore i_tx_done outside SEND.
REQ-022 SHALL register all outputs; o_imem_we, o_wr_uart and STEP-mode o_cpu_enable are single-cycle pulses.

Reset
REQ-023 SHALL, on i_reset high at any time including mid-LOAD, mid-RUN or mid-SEND, immediately force state IDLE, loaded flag 0, counters 0, and all outputs 0.
REQ-024 SHALL resume normal operation on the first rising edge after i_reset is released.

Verification
REQ-025 SHALL cover load: 'L', 00 F0 98 20, FF FF FF FF -> we pulses at addr 0 (0x00F09820) and addr 4 (0xFFFFFFFF), then IDLE, o_busy 0.
REQ-026 SHALL cover run gating: 'C' before any load -> no o_cpu_enable, state stays IDLE.
REQ-027 SHALL cover run: after load, 'C', i_cpu_halt raised 10 cycles later with i_pc = 0x00000008 -> enable high 10 cycles, then TX bytes 00 00 00 08 each gated by i_tx_done.
REQ-028 SHALL cover step: after load, 'S' -> o_cpu_enable high exactly 1 cycle, then 4 PC bytes; 'S' with i_cpu_halt high -> no enable, 4 PC bytes.
REQ-029 SHALL cover reset: i_reset pulsed after 2 bytes of a LOAD word -> no we pulse, outputs 0; a subsequent 'C' is ignored (loaded flag cleared).
REQ-030 SHALL cover robustness: 0x41 in IDLE and bytes received during SEND -> ignored; TX sequence unchanged.
